divider_arbiter: RTL and testbench
==================================

# divider_arbiter

Round-robin arbiter and sequencer that shares one `divider_param` instance among `NREQ` requesters. It sits between client blocks and the divider. It accepts one division job at a time over per-requester valid/ready handshakes, launches the divider, and tracks its `idle` flag to detect completion. Results return on a single tagged response channel. Divide-by-zero is resolved locally without using the divider.

## Interface
- `NREQ`, 4, number of requesters (2..16)
- `BITSIZE`, 16, operand/result width, passed to divider
- `INDEXSIZE`, 4, log2(BITSIZE), passed to divider
- `IDW`, 2, log2(NREQ), width of requester id
- `WDOG`, 2*BITSIZE+4, watchdog limit in cycles for one divider job
- `clk` in 1: single clock
- `rst` in 1: reset, synchronous, active-high; also drives divider `rst`
- `req_valid` in NREQ: request pending, one bit per requester
- `req_ready` out NREQ: one-hot accept pulse; the job transfers when valid&ready
- `req_dividend` in NREQ*BITSIZE: requester i occupies slice [i*BITSIZE +: BITSIZE]
- `req_divisor` in NREQ*BITSIZE: same packing as `req_dividend`
- `rsp_valid` out 1: response available
- `rsp_ready` in 1: consumer accepts response
- `rsp_id` out IDW: requester index of the response
- `rsp_quotient`, `rsp_remainder` out BITSIZE: result
- `rsp_div_zero` out 1: divisor was 0
- `rsp_error` out 1: watchdog expired, result invalid
- `busy` out 1: state != S_IDLE

## Operation
- States: S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE, S_RESP.
- **S_IDLE**
  - If any `req_valid` is set, grant the first set bit at or after `rr_ptr`, searching with wrap-around.
  - Assert `req_ready[g]` for that cycle only.
  - Latch dividend, divisor and id.
  - Set `rr_ptr` to (g+1) mod NREQ.
  - If the latched divisor is 0: quotient = all-ones, remainder = dividend, `div_zero` = 1, go to S_RESP.
  - Otherwise go to S_ISSUE.
- **S_ISSUE**
  - Drive divider `strt` = 1 with the latched operands. Operands are held on the divider inputs in every state.
  - Go to S_WAIT_START.
- **S_WAIT_START**: wait for divider `idle` = 0, then go to S_WAIT_DONE.
- **S_WAIT_DONE**
  - Wait for divider `idle` = 1.
  - In that cycle, capture `quotient` and `remainder`, then go to S_RESP.
- **Watchdog**
  - Counter cleared in S_ISSUE; increments in S_WAIT_START and S_WAIT_DONE.
  - When it reaches `WDOG`: set `rsp_error` = 1, quotient = remainder = 0, go to S_RESP.
- **S_RESP**
  - `rsp_valid` = 1, all response fields held stable.
  - On `rsp_valid & rsp_ready`, clear the flags and go to S_IDLE.
- No request is accepted in any state other than S_IDLE. `req_ready` is 0 in all other states.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0
  - `rsp_quotient` = 0, `rsp_remainder` = 0
  - `rsp_div_zero` = 0, `rsp_error` = 0, `busy` = 0
  - `rr_ptr` = 0, state = S_IDLE
- Divider `strt` is high for exactly 1 cycle per job, only in S_ISSUE.
- Divide-by-zero latency: acceptance edge to `rsp_valid` = 1 cycle.
- Normal latency: acceptance to `rsp_valid` = divider run time + 3 cycles.
- The earliest next acceptance is the cycle after the response handshake. Minimum 1 idle cycle between jobs.
- Simultaneous requests: at most one grant per cycle. A requester that does not hold `req_valid` loses its turn.
- Reset mid-job:
  - The job is discarded with no response.
  - The divider is reset with it.
  - The requester must re-issue.
- A `rsp_ready` held high before `rsp_valid` completes the handshake in the first S_RESP cycle.

## Structure
- Shared package `divider_pkg`:
  - State encodings for S_IDLE through S_RESP.
  - Divide-by-zero constants: quotient fill pattern, div_zero flag value.
  - Default `WDOG` expression.
- Exactly one sub-module: `divider_param`, instance `u_div`. `clk` and `rst` are shared with it.
- Grant logic is a combinational rotate-priority function inside this module. It is not a separate module.

## Test plan
- Single requester 0: dividend 100, divisor 7 -> `rsp_id` = 0, quotient 14, remainder 2; `strt` pulsed once.
- Requesters 0..3 all valid from reset with ops 1000/10, 1000/3, 65535/1, 5/9 -> responses with ids 0,1,2,3 in order:
  - 100 r0
  - 333 r1
  - 65535 r0
  - 0 r5
- Requester 2: 1234/0 -> `rsp_valid` 1 cycle after acceptance, quotient 0xFFFF, remainder 1234, `rsp_div_zero` = 1, divider `strt` never asserted.
- `rsp_ready` held low 20 cycles after `rsp_valid` -> fields stable, `req_ready` stays 0 while requester 1 waits; requester 1 is granted the cycle after the handshake.
- `rst` pulsed during S_WAIT_DONE -> next cycle all outputs at reset values, `busy` = 0, no response for the aborted job, new job 50/5 returns 10 r0.
- Divider `idle` forced high after start (fault injection) -> `rsp_error` = 1 after `WDOG` cycles, quotient 0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the divider arbiter: FSM encoding, divide-by-zero
// response constants and the default watchdog limit.
package divider_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_RESP       = 3'd4
  } state_t;

  localparam logic DZ_FILL_BIT = 1'b1;
  localparam logic DZ_FLAG     = 1'b1;
  localparam int   WDOG_SLACK  = 4;

  function automatic int wdog_default(input int bitsize);
    return 2 * bitsize + WDOG_SLACK;
  endfunction

endpackage

// File: rtl/divider_param.sv
// Sequential restoring divider: one quotient bit per cycle after strt,
// idle drops while running and rises with the result valid.
module divider_param #(
  parameter int BITSIZE   = 16,
  parameter int INDEXSIZE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               strt,
  input  logic [BITSIZE-1:0] dividend,
  input  logic [BITSIZE-1:0] divisor,
  output logic [BITSIZE-1:0] quotient,
  output logic [BITSIZE-1:0] remainder,
  output logic               idle
);

  logic [BITSIZE-1:0]   quo_r;
  logic [BITSIZE-1:0]   rem_r;
  logic [INDEXSIZE-1:0] cnt_r;
  logic                 idle_r;
  logic [BITSIZE:0]     trial_s;
  logic [BITSIZE:0]     diff_s;
  logic                 fits_s;

  // Trial subtraction for the current quotient bit
  always_comb begin
    trial_s = {rem_r, quo_r[BITSIZE-1]};
    diff_s  = trial_s - {1'b0, divisor};
    fits_s  = (trial_s >= {1'b0, divisor});
  end

  // Iteration state: load on strt, shift one bit per cycle until done
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_r  <= '0;
      rem_r  <= '0;
      cnt_r  <= '0;
      idle_r <= 1'b1;
    end else if (idle_r) begin
      if (strt) begin
        quo_r  <= dividend;
        rem_r  <= '0;
        cnt_r  <= '0;
        idle_r <= 1'b0;
      end
    end else begin
      quo_r <= {quo_r[BITSIZE-2:0], fits_s};
      rem_r <= fits_s ? diff_s[BITSIZE-1:0] : trial_s[BITSIZE-1:0];
      if (cnt_r == INDEXSIZE'(BITSIZE - 1)) begin
        idle_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + {{(INDEXSIZE-1){1'b0}}, 1'b1};
      end
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;
  assign idle      = idle_r;

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin front end that serialises division jobs from NREQ clients onto
// one shared divider and returns tagged results on a single response channel.
module divider_arbiter
  import divider_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int BITSIZE   = 16,
  parameter int INDEXSIZE = 4,
  parameter int IDW       = 2,
  parameter int WDOG      = wdog_default(BITSIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*BITSIZE-1:0] req_dividend,
  input  logic [NREQ*BITSIZE-1:0] req_divisor,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [BITSIZE-1:0]      rsp_quotient,
  output logic [BITSIZE-1:0]      rsp_remainder,
  output logic                    rsp_div_zero,
  output logic                    rsp_error,
  output logic                    busy
);

  localparam int WDW = $clog2(WDOG + 1);

  state_t               state_r, state_n;
  logic [IDW-1:0]       rr_ptr_r, id_r, gnt_id_s, next_ptr_s;
  logic [BITSIZE-1:0]   dividend_r, divisor_r, quo_r, rem_r;
  logic [BITSIZE-1:0]   sel_dividend_s, sel_divisor_s, div_q_s, div_r_s;
  logic [WDW-1:0]       wdog_r;
  logic                 dz_r, err_r, rsp_valid_r, busy_r;
  logic                 any_valid_s, accept_s, wdog_exp_s, div_strt_s, div_idle_s;

  // First valid requester at or after ptr, searching with wrap-around
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW:0]   pos;
    logic [IDW-1:0] pick;
    logic           found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (IDW+1)'(k);
      pos = (pos >= (IDW+1)'(NREQ)) ? pos - (IDW+1)'(NREQ) : pos;
      if (!found && valid[pos[IDW-1:0]]) begin
        pick  = pos[IDW-1:0];
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // Grant selection and operand mux for the granted requester
  always_comb begin
    any_valid_s    = |req_valid;
    gnt_id_s       = rr_pick(req_valid, rr_ptr_r);
    next_ptr_s     = (gnt_id_s == IDW'(NREQ - 1)) ? '0 : gnt_id_s + IDW'(1);
    accept_s       = (state_r == S_IDLE) && any_valid_s;
    wdog_exp_s     = (wdog_r == WDW'(WDOG));
    sel_dividend_s = '0;
    sel_divisor_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_dividend_s = (gnt_id_s == IDW'(i)) ? req_dividend[i*BITSIZE +: BITSIZE] : sel_dividend_s;
      sel_divisor_s  = (gnt_id_s == IDW'(i)) ? req_divisor[i*BITSIZE +: BITSIZE]  : sel_divisor_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; a finished divider wins over a simultaneous watchdog expiry
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_n = (sel_divisor_s == '0) ? S_RESP : S_ISSUE;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_ISSUE:      state_n = S_WAIT_START;
      S_WAIT_START: begin
        if (!div_idle_s)     state_n = S_WAIT_DONE;
        else if (wdog_exp_s) state_n = S_RESP;
        else                 state_n = S_WAIT_START;
      end
      S_WAIT_DONE: begin
        if (div_idle_s || wdog_exp_s) state_n = S_RESP;
        else                          state_n = S_WAIT_DONE;
      end
      S_RESP: begin
        if (rsp_ready) state_n = S_IDLE;
        else           state_n = S_RESP;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Decoded outputs; requests are only offered a grant from idle, never in reset
  always_comb begin
    if (accept_s && !rst) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_id_s;
    end else begin
      req_ready = '0;
    end
    div_strt_s = (state_r == S_ISSUE);
  end

  // Job capture, watchdog and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      id_r        <= '0;
      dividend_r  <= '0;
      divisor_r   <= '0;
      quo_r       <= '0;
      rem_r       <= '0;
      dz_r        <= 1'b0;
      err_r       <= 1'b0;
      wdog_r      <= '0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rsp_valid_r <= (state_n == S_RESP);
      busy_r      <= (state_n != S_IDLE);
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            id_r       <= gnt_id_s;
            dividend_r <= sel_dividend_s;
            divisor_r  <= sel_divisor_s;
            rr_ptr_r   <= next_ptr_s;
            if (sel_divisor_s == '0) begin
              quo_r <= {BITSIZE{DZ_FILL_BIT}};
              rem_r <= sel_dividend_s;
              dz_r  <= DZ_FLAG;
            end
          end
        end
        S_ISSUE: wdog_r <= '0;
        S_WAIT_START: begin
          if (div_idle_s && wdog_exp_s) begin
            err_r <= 1'b1;
            quo_r <= '0;
            rem_r <= '0;
          end else begin
            wdog_r <= wdog_r + WDW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (div_idle_s) begin
            quo_r <= div_q_s;
            rem_r <= div_r_s;
          end else if (wdog_exp_s) begin
            err_r <= 1'b1;
            quo_r <= '0;
            rem_r <= '0;
          end else begin
            wdog_r <= wdog_r + WDW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            dz_r  <= 1'b0;
            err_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  divider_param #(
    .BITSIZE  (BITSIZE),
    .INDEXSIZE(INDEXSIZE)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .strt     (div_strt_s),
    .dividend (dividend_r),
    .divisor  (divisor_r),
    .quotient (div_q_s),
    .remainder(div_r_s),
    .idle     (div_idle_s)
  );

  assign rsp_valid     = rsp_valid_r;
  assign rsp_id        = id_r;
  assign rsp_quotient  = quo_r;
  assign rsp_remainder = rem_r;
  assign rsp_div_zero  = dz_r;
  assign rsp_error     = err_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_divider_arbiter.sv
// Scoreboard bench for divider_arbiter: expected results are queued when a
// job is accepted and compared when the response handshake happens.
module tb_divider_arbiter;

  localparam int NREQ = 4;
  localparam int BW   = 16;
  localparam int WDOG = 2 * BW + 4;

  typedef struct {
    logic [1:0]    id;
    logic [BW-1:0] q;
    logic [BW-1:0] r;
    logic          dz;
    logic          err;
  } exp_t;

  logic               clk, rst;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*BW-1:0] req_dividend, req_divisor;
  logic               rsp_valid, rsp_ready;
  logic [1:0]         rsp_id;
  logic [BW-1:0]      rsp_quotient, rsp_remainder;
  logic               rsp_div_zero, rsp_error, busy;

  exp_t       sb[$];
  logic [1:0] rsp_log[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_rsp    = 0;
  int         strt_cnt = 0;
  bit         fault_mode = 1'b0;

  divider_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_div_zero(rsp_div_zero), .rsp_error(rsp_error), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b);
    req_dividend[i*BW +: BW] = a;
    req_divisor[i*BW +: BW]  = b;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int c = 0;
    while (n_rsp < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("rsp_timeout", 32'(n_rsp >= target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, "_quotient"}, 32'(rsp_quotient), 32'd0);
    check({tag, "_remainder"}, 32'(rsp_remainder), 32'd0);
    check({tag, "_div_zero"}, 32'(rsp_div_zero), 32'd0);
    check({tag, "_error"}, 32'(rsp_error), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Requester side: on each accepted job queue the model result and drop valid
  initial begin
    logic [NREQ-1:0] hs;
    exp_t e;
    logic [BW-1:0] a, b;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      if (hs != '0) begin
        check("grant_onehot", 32'($countones(hs)), 32'd1);
        for (int i = 0; i < NREQ; i++) begin
          if (hs[i]) begin
            a = req_dividend[i*BW +: BW];
            b = req_divisor[i*BW +: BW];
            e.id = 2'(i);
            if (fault_mode) begin
              e.q = '0; e.r = '0; e.dz = 1'b0; e.err = 1'b1;
            end else if (b == '0) begin
              e.q = 16'hFFFF; e.r = a; e.dz = 1'b1; e.err = 1'b0;
            end else begin
              e.q = a / b; e.r = a % b; e.dz = 1'b0; e.err = 1'b0;
            end
            sb.push_back(e);
          end
        end
        @(posedge clk);
        #1 req_valid = req_valid & ~hs;
      end
    end
  end

  // Response side: compare each handshaken response with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_quotient", 32'(rsp_quotient), 32'(e.q));
          check("rsp_remainder", 32'(rsp_remainder), 32'(e.r));
          check("rsp_div_zero", 32'(rsp_div_zero), 32'(e.dz));
          check("rsp_error", 32'(rsp_error), 32'(e.err));
        end
        rsp_log.push_back(rsp_id);
        n_rsp++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (dut.div_strt_s) strt_cnt++;
    end
  end

  initial begin
    int s0, c;
    bit stable, ready_seen, got;
    logic [BW-1:0] cap_q, cap_r;
    logic [1:0] cap_id;

    // All four requesters valid out of reset
    rst = 1'b1; rsp_ready = 1'b1; req_valid = '0;
    req_dividend = '0; req_divisor = '0;
    set_op(0, 16'd1000, 16'd10);
    set_op(1, 16'd1000, 16'd3);
    set_op(2, 16'd65535, 16'd1);
    set_op(3, 16'd5, 16'd9);
    req_valid = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    wait_rsp(4, 400);
    for (int i = 0; i < 4; i++) begin
      check("rr_order", 32'(rsp_log[i]), 32'(i));
    end
    check("strt_four_jobs", 32'(strt_cnt), 32'd4);

    // Single requester 0: 100 / 7
    s0 = strt_cnt;
    set_op(0, 16'd100, 16'd7);
    @(posedge clk); #1 req_valid[0] = 1'b1;
    wait_rsp(5, 200);
    check("strt_single_pulse", 32'(strt_cnt - s0), 32'd1);

    // Divide by zero on requester 2, response one cycle after acceptance
    s0 = strt_cnt;
    @(posedge clk); #1 rsp_ready = 1'b0;
    set_op(2, 16'd1234, 16'd0);
    req_valid[2] = 1'b1;
    c = 0;
    while (!req_ready[2] && c < 20) begin @(negedge clk); c++; end
    check("dz_grant_seen", 32'(req_ready[2]), 32'd1);
    @(negedge clk);
    check("dz_latency", 32'(rsp_valid), 32'd1);
    check("dz_quotient", 32'(rsp_quotient), 32'hFFFF);
    check("dz_remainder", 32'(rsp_remainder), 32'd1234);
    check("dz_flag", 32'(rsp_div_zero), 32'd1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_rsp(6, 50);
    check("dz_no_strt", 32'(strt_cnt - s0), 32'd0);

    // Back-pressure: response held 20 cycles while requester 1 waits
    @(posedge clk); #1 rsp_ready = 1'b0;
    set_op(0, 16'd200, 16'd9);
    req_valid[0] = 1'b1;
    c = 0;
    while (!rsp_valid && c < 100) begin @(negedge clk); c++; end
    check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    cap_q = rsp_quotient; cap_r = rsp_remainder; cap_id = rsp_id;
    set_op(1, 16'd77, 16'd7);
    req_valid[1] = 1'b1;
    stable = 1'b1; ready_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid || rsp_quotient != cap_q || rsp_remainder != cap_r || rsp_id != cap_id)
        stable = 1'b0;
      if (req_ready != '0) ready_seen = 1'b1;
    end
    check("bp_fields_stable", 32'(stable), 32'd1);
    check("bp_no_ready", 32'(ready_seen), 32'd0);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_next_grant", 32'(req_ready), 32'b0010);
    wait_rsp(8, 200);

    // Reset while the divider is running: job dropped, no response
    set_op(3, 16'd1000, 16'd3);
    @(posedge clk); #1 req_valid[3] = 1'b1;
    c = 0;
    while (!dut.div_strt_s && c < 20) begin @(negedge clk); c++; end
    repeat (5) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_outputs("abort");
    check("abort_div_idle", 32'(dut.div_idle_s), 32'd1);
    s0 = n_rsp;
    got = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    check("abort_no_rsp", 32'(got), 32'd0);
    set_op(0, 16'd50, 16'd5);
    @(posedge clk); #1 req_valid[0] = 1'b1;
    wait_rsp(s0 + 1, 200);

    // Divider idle stuck high after start: watchdog error
    s0 = n_rsp;
    fault_mode = 1'b1;
    set_op(1, 16'd500, 16'd5);
    @(posedge clk); #1 req_valid[1] = 1'b1;
    c = 0;
    while (!dut.div_strt_s && c < 20) begin @(negedge clk); c++; end
    force dut.div_idle_s = 1'b1;
    c = 0;
    while (!rsp_valid && c < 200) begin @(negedge clk); c++; end
    check("wdog_rsp_seen", 32'(rsp_valid), 32'd1);
    check("wdog_delay", 32'(c >= WDOG && c <= WDOG + 3), 32'd1);
    wait_rsp(s0 + 1, 20);
    release dut.div_idle_s;
    fault_mode = 1'b0;
    repeat (30) @(negedge clk);

    // Normal job after the fault clears
    s0 = n_rsp;
    set_op(2, 16'd65535, 16'd255);
    @(posedge clk); #1 req_valid[2] = 1'b1;
    wait_rsp(s0 + 1, 200);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
